// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through FETCH -> DECODE -> EXEC -> MEM -> WB (as
// needed) and drives the datapath strobes and mux selects for the current
// state. Memory accesses in FETCH and MEM wait for mem_ready; a stall longer
// than MEM_TIMEOUT cycles, or an unknown instruction, parks the block in ERR
// until reset.
//
// Parameters:
//   MEM_TIMEOUT   consecutive mem_ready-low cycles in FETCH/MEM before ERR
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous, active-low reset
//   opcode        IR[31:26]
//   funct         IR[5:0]
//   zero          ALU zero flag (used by beq)
//   mem_ready     shared memory completes the current access this cycle
//   pc_write, ir_write, reg_write    register write strobes
//   mem_read, mem_write              shared-memory access strobes
//   i_or_d        memory address source: 0 = PC, 1 = ALU result
//   s_npc         next-PC select: 00 pc+4, 01 jump, 10 rs, 11 branch
//   s_num_write   write-register select: 00 rt, 01 rd, 10 r31
//   s_data_write  write-data select: 00 ALU, 01 memory, 10 pc+4
//   s_b           ALU B select: 0 = rt, 1 = extended immediate
//   s_ext         immediate extension: 1 = sign, 0 = zero
//   alu_op        00 add, 01 sub, 10 from funct, 11 or
//   state         current state encoding
//   illegal       sticky illegal-instruction flag
//   retired       count of cycles with pc_write=1 (retired instructions)
// -----------------------------------------------------------------------------
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic [1:0]  s_npc,
  output logic [1:0]  s_num_write,
  output logic [1:0]  s_data_write,
  output logic        s_b,
  output logic        s_ext,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  // Instruction class decoded from opcode/funct.
  typedef enum logic [3:0] {
    C_J, C_JAL, C_JR, C_RTYPE, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_ILL
  } iclass_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            illegal_q;
  logic [31:0]     retired_q;

  iclass_t         iclass;
  logic            set_illegal;
  logic            timeout_hit;
  logic            pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  always_comb begin
    iclass = C_ILL;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b001000:                       iclass = C_JR;
          6'b100001, 6'b100011, 6'b101010: iclass = C_RTYPE;
          default:                         iclass = C_ILL;
        endcase
      end
      6'b000010: iclass = C_J;
      6'b000011: iclass = C_JAL;
      6'b001000: iclass = C_ADDI;
      6'b001101: iclass = C_ORI;
      6'b100011: iclass = C_LW;
      6'b101011: iclass = C_SW;
      6'b000100: iclass = C_BEQ;
      default:   iclass = C_ILL;
    endcase
  end

  // A stall expires on the edge where the counter already holds
  // MEM_TIMEOUT-1 and memory is still not ready.
  assign timeout_hit = !mem_ready && (wait_q == CW'(MEM_TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    set_illegal  = 1'b0;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d       = 1'b0;
    s_npc        = 2'b00;
    s_num_write  = 2'b00;
    s_data_write = 2'b00;
    s_b          = 1'b0;
    s_ext        = 1'b0;
    alu_op       = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end

      S_DECODE: begin
        case (iclass)
          C_J: begin
            pc_write_c = 1'b1;
            s_npc      = 2'b01;
            state_d    = S_FETCH;
          end
          C_JAL: begin
            pc_write_c   = 1'b1;
            s_npc        = 2'b01;
            reg_write_c  = 1'b1;
            s_num_write  = 2'b10;
            s_data_write = 2'b10;
            state_d      = S_FETCH;
          end
          C_JR: begin
            pc_write_c = 1'b1;
            s_npc      = 2'b10;
            state_d    = S_FETCH;
          end
          C_ILL: begin
            set_illegal = 1'b1;
            state_d     = S_ERR;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (iclass)
          C_RTYPE: begin
            alu_op  = 2'b10;
            state_d = S_WB;
          end
          C_ADDI: begin
            s_b     = 1'b1;
            s_ext   = 1'b1;
            state_d = S_WB;
          end
          C_ORI: begin
            alu_op  = 2'b11;
            s_b     = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            s_b     = 1'b1;
            s_ext   = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_op     = 2'b01;
            pc_write_c = 1'b1;
            s_npc      = zero ? 2'b11 : 2'b00;
            state_d    = S_FETCH;
          end
          default: state_d = S_ERR;
        endcase
      end

      S_MEM: begin
        i_or_d      = 1'b1;
        mem_read_c  = (iclass == C_LW);
        mem_write_c = (iclass == C_SW);
        if (mem_ready) begin
          if (iclass == C_LW) begin
            state_d = S_WB;
          end else if (iclass == C_SW) begin
            pc_write_c = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_ERR;
          end
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        s_num_write  = (iclass == C_RTYPE) ? 2'b01 : 2'b00;
        s_data_write = (iclass == C_LW) ? 2'b01 : 2'b00;
        pc_write_c   = 1'b1;
        state_d      = S_FETCH;
      end

      // ERR and unused encodings hold with every strobe low.
      default: state_d = S_ERR;
    endcase
  end

  // The stall counter only counts while a memory access is outstanding and
  // restarts on any state change.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d = wait_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_q | set_illegal;
      if (pc_write_c) retired_q <= retired_q + 32'd1;
    end
  end

  // Strobes are forced low while reset is held so an aborted instruction
  // cannot write anything in the reset cycle.
  assign pc_write  = pc_write_c  & reset;
  assign ir_write  = ir_write_c  & reset;
  assign reg_write = reg_write_c & reset;
  assign mem_read  = mem_read_c  & reset;
  assign mem_write = mem_write_c & reset;

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
//
// Instructions are described at the instruction level: each one expands into
// its expected per-cycle output records (fetch waits, decode, exec, memory
// waits, write-back) which are queued and compared against the DUT on the
// falling edge of every cycle. Directed cases are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d;
  logic [1:0]  s_npc, s_num_write, s_data_write, alu_op;
  logic        s_b, s_ext;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  always #5 clock = ~clock;

  mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .i_or_d      (i_or_d),
    .s_npc       (s_npc),
    .s_num_write (s_num_write),
    .s_data_write(s_data_write),
    .s_b         (s_b),
    .s_ext       (s_ext),
    .alu_op      (alu_op),
    .state       (state),
    .illegal     (illegal),
    .retired     (retired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, irw, rgw, mrd, mwr, iod;
    logic [1:0]  npc, nwr, dwr;
    logic        sb, se;
    logic [1:0]  alu;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  typedef enum int {K_J, K_JAL, K_JR, K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_ILL} kind_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ret_m  = '0;
  logic        ill_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h21 || fn == 6'h23 || fn == 6'h2A) return K_R;
      return K_ILL;
    end
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    return K_ILL;
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Compare process: one queued expectation per cycle, checked mid-cycle.
  always @(negedge clock) begin : compare
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("state",        32'(state),        32'(e.st));
      check("pc_write",     32'(pc_write),     32'(e.pcw));
      check("ir_write",     32'(ir_write),     32'(e.irw));
      check("reg_write",    32'(reg_write),    32'(e.rgw));
      check("mem_read",     32'(mem_read),     32'(e.mrd));
      check("mem_write",    32'(mem_write),    32'(e.mwr));
      check("i_or_d",       32'(i_or_d),       32'(e.iod));
      check("s_npc",        32'(s_npc),        32'(e.npc));
      check("s_num_write",  32'(s_num_write),  32'(e.nwr));
      check("s_data_write", 32'(s_data_write), 32'(e.dwr));
      check("s_b",          32'(s_b),          32'(e.sb));
      check("s_ext",        32'(s_ext),        32'(e.se));
      check("alu_op",       32'(alu_op),       32'(e.alu));
      check("illegal",      32'(illegal),      32'(e.ill));
      check("retired",      retired,           e.ret);
    end
  end

  // Drive one cycle (called just after a rising edge) and queue what the DUT
  // must show during it; returns just after the following rising edge.
  task automatic emit(input exp_t e, input logic rdy, input logic z, input logic rst);
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    e.ret     = ret_m;
    e.ill     = ill_m;
    if (!rst) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.rgw = 1'b0; e.mrd = 1'b0; e.mwr = 1'b0;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (!rst) begin
      ret_m = '0;
      ill_m = 1'b0;
    end else if (e.pcw) begin
      ret_m = ret_m + 32'd1;
    end
  endtask

  // One reset cycle taken from the idle FETCH state.
  task automatic do_reset();
    exp_t e;
    e     = blank(3'd0);
    e.mrd = 1'b1;
    emit(e, rbit(), rbit(), 1'b0);
  endtask

  // One instruction: fw stalled fetch cycles, mw stalled memory cycles,
  // optional reset in the first MEM cycle.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw, input bit abort);
    exp_t  e;
    kind_t k;
    opcode = op;
    funct  = fn;
    k      = classify(op, fn);

    for (int i = 0; i < fw; i++) begin
      e = blank(3'd0); e.mrd = 1'b1;
      emit(e, 1'b0, rbit(), 1'b1);
    end
    e = blank(3'd0); e.mrd = 1'b1; e.irw = 1'b1;
    emit(e, 1'b1, rbit(), 1'b1);

    e = blank(3'd1);
    case (k)
      K_J:   begin e.pcw = 1'b1; e.npc = 2'b01; end
      K_JAL: begin e.pcw = 1'b1; e.npc = 2'b01; e.rgw = 1'b1; e.nwr = 2'b10; e.dwr = 2'b10; end
      K_JR:  begin e.pcw = 1'b1; e.npc = 2'b10; end
      default: ;
    endcase
    emit(e, rbit(), rbit(), 1'b1);
    if (k == K_ILL) begin
      ill_m = 1'b1;
      return;
    end
    if (k == K_J || k == K_JAL || k == K_JR) return;

    e = blank(3'd2);
    case (k)
      K_R:        begin e.alu = 2'b10; end
      K_ADDI:     begin e.sb = 1'b1; e.se = 1'b1; end
      K_ORI:      begin e.alu = 2'b11; e.sb = 1'b1; end
      K_LW, K_SW: begin e.sb = 1'b1; e.se = 1'b1; end
      default:    begin e.alu = 2'b01; e.pcw = 1'b1; e.npc = z ? 2'b11 : 2'b00; end
    endcase
    emit(e, rbit(), (k == K_BEQ) ? z : rbit(), 1'b1);
    if (k == K_BEQ) return;

    if (k == K_LW || k == K_SW) begin
      e = blank(3'd3); e.iod = 1'b1; e.mrd = (k == K_LW); e.mwr = (k == K_SW);
      if (abort) begin
        emit(e, rbit(), rbit(), 1'b0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_retired", retired, 32'd0);
        return;
      end
      for (int i = 0; i < mw; i++) emit(e, 1'b0, rbit(), 1'b1);
      if (k == K_SW) e.pcw = 1'b1;
      emit(e, 1'b1, rbit(), 1'b1);
      if (k == K_SW) return;
    end

    e = blank(3'd4);
    e.rgw = 1'b1; e.pcw = 1'b1;
    e.nwr = (k == K_R)  ? 2'b01 : 2'b00;
    e.dwr = (k == K_LW) ? 2'b01 : 2'b00;
    emit(e, rbit(), rbit(), 1'b1);
  endtask

  // Sit in ERR for n cycles, then leave it through reset.
  task automatic err_and_recover(input int n, input logic want_ill);
    check("err_state", 32'(state), 32'd5);
    check("err_illegal", 32'(illegal), 32'(want_ill));
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      emit(blank(3'd5), rbit(), rbit(), 1'b1);
    end
    emit(blank(3'd5), rbit(), rbit(), 1'b0);
    check("recover_state", 32'(state), 32'd0);
    check("recover_illegal", 32'(illegal), 32'd0);
  endtask

  logic [5:0] rop [0:10];
  logic [5:0] rfn [0:2];

  initial begin
    rop = '{6'h02, 6'h03, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h00, 6'h00};
    rfn = '{6'h21, 6'h23, 6'h2A};
    reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_mem_read_forced", 32'(mem_read), 32'd0);
    check("reset_retired", retired, 32'd0);

    // lw, memory always ready: five cycles, one retirement.
    do_instr(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);
    check("lw_retired", retired, 32'd1);
    check("lw_end_state", 32'(state), 32'd0);

    // beq taken then not taken.
    do_reset();
    do_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    do_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    check("beq_retired", retired, 32'd2);

    // jal.
    do_reset();
    do_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
    check("jal_retired", retired, 32'd1);

    // sw with three stalled memory cycles, then a fetch stall at the limit.
    do_reset();
    do_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1'b0);
    check("sw_retired", retired, 32'd1);
    check("sw_end_state", 32'(state), 32'd0);
    do_instr(6'h0D, 6'h00, 1'b0, TO - 1, 0, 1'b0);
    check("ori_late_ready_retired", retired, 32'd2);

    // Fetch timeout: eight stalled cycles land in ERR.
    do_reset();
    for (int i = 0; i < TO; i++) begin
      exp_t e;
      e = blank(3'd0); e.mrd = 1'b1;
      emit(e, 1'b0, rbit(), 1'b1);
    end
    err_and_recover(3, 1'b0);

    // Illegal opcode.
    do_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    err_and_recover(2, 1'b1);

    // Reset during the MEM cycle of lw.
    do_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    do_instr(6'h23, 6'h00, 1'b0, 1, 0, 1'b1);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      int          pick;
      logic [5:0]  op, fn;
      kind_t       k;
      pick = $urandom_range(0, 12);
      if (pick <= 10) begin
        op = rop[pick];
        fn = 6'($urandom);
        if (pick == 2)       fn = 6'h08;
        else if (pick >= 3 && op == 6'h00) fn = rfn[$urandom_range(0, 2)];
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      k = classify(op, fn);
      do_instr(op, fn, rbit(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
               (k == K_LW || k == K_SW) && ($urandom_range(0, 19) == 0));
      if (k == K_ILL) err_and_recover($urandom_range(1, 3), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 8, meaning the number of consecutive cycles with mem_ready low in FETCH or MEM before ERR is entered.
REQ-002 The block SHALL have port clock  in  1  sole clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have port opcode  in  6  IR[31:26].
REQ-005 The block SHALL have port funct  in  6  IR[5:0].
REQ-006 The block SHALL have port zero  in  1  ALU zero flag.
REQ-007 The block SHALL have port mem_ready  in  1  shared memory completes the current access this cycle.
REQ-008 The block SHALL have port pc_write / ir_write / reg_write  out  1 each  register write strobes.
REQ-009 The block SHALL have port mem_read / mem_write  out  1 each  shared-memory access strobes.
REQ-010 The block SHALL have port i_or_d  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-011 The block SHALL have port s_npc  out  2  next-PC select: 00 pc+4, 01 jump target, 10 rs, 11 branch target.
REQ-012 The block SHALL have port s_num_write  out  2  write-register select: 00 rt, 01 rd, 10 r31.
REQ-013 The block SHALL have port s_data_write  out  2  write-data select: 00 ALU, 01 memory, 10 pc+4.
REQ-014 The block SHALL have port s_b  out  1  ALU B select: 0 = rt, 1 = extended immediate.
REQ-015 The block SHALL have port s_ext  out  1  immediate extension: 1 = sign, 0 = zero.
REQ-016 The block SHALL have port alu_op  out  2  ALU operation: 00 add, 01 sub, 10 from funct, 11 or.
REQ-017 The block SHALL have port state  out  3  current state encoding.
REQ-018 The block SHALL have port illegal  out  1  sticky illegal-instruction flag.
REQ-019 The block SHALL have port retired  out  32  count of retired instructions.

Function
REQ-020 The block SHALL encode states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5; any output or select not listed for a state SHALL be 0.
REQ-021 FETCH SHALL assert mem_read=1 and i_or_d=0; on mem_ready=1 it SHALL assert ir_write=1 and go to DECODE, otherwise it SHALL stay in FETCH.
REQ-022 DECODE SHALL handle instructions as follows:
- j (000010): pc_write=1, s_npc=01, then FETCH.
- jal (000011): pc_write=1, s_npc=01, reg_write=1, s_num_write=10, s_data_write=10, then FETCH.
- R-type (000000) with funct 001000 (jr): pc_write=1, s_npc=10, then FETCH.
- R-type with funct addu 100001, subu 100011 or slt 101010; addi 001000; ori 001101; lw 100011; sw 101011; beq 000100: go to EXEC.
- Anything else: illegal=1, then ERR.
REQ-023 EXEC SHALL drive the ALU and branch by class:
- R-type: alu_op=10, s_b=0, then WB.
- addi: alu_op=00, s_b=1, s_ext=1, then WB.
- ori: alu_op=11, s_b=1, s_ext=0, then WB.
- lw/sw: alu_op=00, s_b=1, s_ext=1, then MEM.
- beq: alu_op=01, s_b=0, pc_write=1, s_npc = zero ? 11 : 00, then FETCH.
REQ-024 MEM SHALL assert i_or_d=1, with mem_read=1 for lw or mem_write=1 for sw, holding the strobe until mem_ready=1.
- lw with ready: go to WB.
- sw with ready: pc_write=1, s_npc=00, then FETCH.
REQ-025 WB SHALL assert reg_write=1, s_num_write=01 for R-type else 00, s_data_write=01 for lw else 00, pc_write=1 and s_npc=00, then go to FETCH.
REQ-026 A wait counter SHALL increment each FETCH/MEM cycle with mem_ready=0 and SHALL clear on every state change.
REQ-027 When mem_ready=1 the block SHALL proceed regardless of the counter value.
REQ-028 When mem_ready=0 and the counter equals MEM_TIMEOUT-1, the block SHALL enter ERR on that clock edge.
REQ-029 ERR SHALL hold all strobes at 0 and SHALL be left only by reset.
REQ-030 retired SHALL increment by 1 on every cycle with pc_write=1, wrapping from 0xFFFFFFFF to 0.
REQ-031 All outputs except state, illegal and retired SHALL be combinational functions of state, opcode, funct, zero and mem_ready.

Reset
REQ-032 On a rising clock edge with reset=0 the block SHALL set state=FETCH, wait counter=0, illegal=0 and retired=0, aborting any instruction in progress.
REQ-033 While reset=0, every strobe output (pc_write, ir_write, reg_write, mem_read, mem_write) SHALL be forced to 0 combinationally.
REQ-034 In the first cycle after reset releases, the block SHALL present state=0 and mem_read=1.

Verification
REQ-035 Bench SHALL cover: lw (opcode 100011) with mem_ready held 1 -> states 0,1,2,3,4 over 5 cycles; reg_write=1 with s_data_write=01 in cycle 5; retired=1.
REQ-036 Bench SHALL cover: beq with zero=1, then beq with zero=0 -> each takes 3 cycles; s_npc=11 then 00; retired=2.
REQ-037 Bench SHALL cover: jal -> 2 cycles; DECODE asserts pc_write, reg_write, s_num_write=10 and s_data_write=10.
REQ-038 Bench SHALL cover: sw with mem_ready low for 3 MEM cycles, then high -> mem_write held for 4 cycles; ends in FETCH.
REQ-039 Bench SHALL cover: mem_ready held 0 in FETCH for 8 cycles -> state=5 after the 8th edge; all strobes 0 thereafter; opcode 111111 -> illegal=1 and state=5.
REQ-040 Bench SHALL cover: reset=0 asserted during MEM of lw -> strobes 0 in that cycle; state=0 and retired=0 after the edge.
